issue_queue: RTL and testbench
==============================

# issue_queue

Parametrised out-of-order issue queue for integer ops, between dispatch and the ALU. It holds up to ENTRIES decoded instructions and snoops NUM_CDB result buses to capture missing operands. Each cycle it issues the oldest fully-ready entry over a valid/ready handshake. Rollback flushes it.

## Interface
- ENTRIES, 16: queue depth, power of two, ≥2
- ROB_W, 4: ROB tag width
- XLEN, 32: data width
- NUM_CDB, 2: number of broadcast buses snooped
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when 0 all state and outputs hold
- rollback  in  1  flush, same effect as rst on state
- in_valid  in  1  dispatch request
- in_ready  out  1  queue can accept (not full)
- in_v1, in_v2  in  XLEN  operand values
- in_q1, in_q2  in  ROB_W  producer tags
- in_q1_need, in_q2_need  in  1  operand still pending
- in_pc, in_imm  in  XLEN  pc and immediate
- in_opcode  in  7, in_funct3  in  3, in_funct7b  in  1  op fields
- in_rob  in  ROB_W  destination ROB entry
- cdb_valid  in  NUM_CDB  per-bus valid
- cdb_rob  in  NUM_CDB*ROB_W  tags, bus k at [k*ROB_W +: ROB_W]
- cdb_val  in  NUM_CDB*XLEN  values, same packing
- out_valid  out  1  issued op valid
- out_ready  in  1  ALU accepts
- out_v1, out_v2, out_pc, out_imm  out  XLEN; out_opcode 7; out_funct3 3; out_funct7b 1; out_rob ROB_W
- count  out  $clog2(ENTRIES)+1  occupied entries

## Operation
- Entry state: used, need1/need2, tags, values, fields; age matrix older[i][j].
- Allocate: when in_valid && in_ready, lowest-index free entry written; row set older-than-none, column of every used entry marks them older.
- Dispatch bypass: pending operand whose tag matches a valid CDB in the same cycle stores cdb_val and clears need.
- Wakeup: every used entry with need set and tag match captures value, clears need. Multiple buses match one tag: lowest bus index wins.
- Ready = used && !need1 && !need2 (registered state only; woken entries issue next cycle at earliest).
- Issue: when !out_valid || out_ready, pick oldest ready entry via age matrix, load output registers, set out_valid, free entry. No ready entry: out_valid cleared if consumed.
- Output is a register: out_* stable while out_valid && !out_ready.
- in_ready = count < ENTRIES, from registered state; an entry freed this cycle is reusable next cycle only.
- Allocate and issue in same cycle allowed; count updates by +1−1.
- rollback (rdy=1): used, out_valid, count cleared; in_valid and CDBs ignored that cycle.
- rst: same as rollback, independent of rdy.

## Timing
- Reset/rollback values: out_valid 0, all out_* data 0, in_ready 1, count 0.
- Latency dispatch→issue: 1 cycle if operands ready at dispatch or bypassed.
- CDB wakeup→issue: 1 cycle.
- Issue throughput: 1 per cycle when out_ready held high.
- rdy=0: no allocate, issue, wakeup; outputs hold; handshakes not counted.

## Structure
- Package issue_pkg: opcode/funct constants, entry struct (XLEN, ROB_W parameterised via localparams), CDB unpack helper function.
- Sub-module rs_age_select: ENTRIES-wide request vector + age matrix in, one-hot grant + valid out, combinational.
- Rest in one module; age matrix update logic stays in parent.

## Test plan
- Reset, then dispatch op with both operands ready, out_ready=1 -> out_valid next cycle with matching out_rob, count back to 0.
- Dispatch A(q1=3 pending) then B(ready); CDB0 tag 3 value 0x55 -> B issues first, A issues next cycle with out_v1=0x55.
- Fill 16 entries all pending -> in_ready=0, count=16; 17th in_valid ignored; broadcast one tag -> single issue, in_ready=1 following cycle.
- Three ready entries, out_ready=0 for 3 cycles -> out_* stable, then issue in allocation order 0,1,2.
- Dispatch with q2=5 pending while CDB1 tag 5 value 0xABCD same cycle -> issues next cycle, out_v2=0xABCD.
- Queue holding 6 entries plus out_valid, assert rollback -> next cycle out_valid=0, count=0, no later issue.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared types and constants for the integer issue queue: op fields, entry payload, CDB unpacking.
package issue_pkg;

    localparam int unsigned IQ_XLEN    = 32;
    localparam int unsigned IQ_ROB_W   = 4;
    localparam int unsigned IQ_NUM_CDB = 2;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;

    typedef struct packed {
        logic [IQ_XLEN-1:0]  v1;
        logic [IQ_XLEN-1:0]  v2;
        logic [IQ_XLEN-1:0]  pc;
        logic [IQ_XLEN-1:0]  imm;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic                funct7b;
        logic [IQ_ROB_W-1:0] rob;
    } iq_op_t;

    typedef struct packed {
        logic                need1;
        logic                need2;
        logic [IQ_ROB_W-1:0] q1;
        logic [IQ_ROB_W-1:0] q2;
        iq_op_t              op;
    } iq_entry_t;

    function automatic logic [IQ_ROB_W-1:0] cdb_tag(
        input logic [IQ_NUM_CDB*IQ_ROB_W-1:0] bus,
        input int unsigned                    k
    );
        return bus[k*IQ_ROB_W +: IQ_ROB_W];
    endfunction

    function automatic logic [IQ_XLEN-1:0] cdb_value(
        input logic [IQ_NUM_CDB*IQ_XLEN-1:0] bus,
        input int unsigned                   k
    );
        return bus[k*IQ_XLEN +: IQ_XLEN];
    endfunction

endpackage

// File: rtl/issue_queue_rs_age_select.sv
// Oldest-first selector: grants the requester that no other requester is older than.
module rs_age_select #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic [ENTRIES-1:0]         req,
    input  logic [ENTRIES*ENTRIES-1:0] older,
    output logic [ENTRIES-1:0]         grant,
    output logic                       valid
);

    // older[j*ENTRIES+i] set means entry j is older than entry i
    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            grant[i] = req[i];
            for (int unsigned j = 0; j < ENTRIES; j++) begin
                if (j != i && req[j] && older[j*ENTRIES+i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
        valid = |req;
    end

endmodule

// File: rtl/issue_queue.sv
// Out-of-order integer issue queue: allocates dispatched ops, snoops CDBs, issues the oldest ready op.
module issue_queue
    import issue_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned ROB_W   = IQ_ROB_W,
    parameter int unsigned XLEN    = IQ_XLEN,
    parameter int unsigned NUM_CDB = IQ_NUM_CDB
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      rollback,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [XLEN-1:0]           in_v1,
    input  logic [XLEN-1:0]           in_v2,
    input  logic [ROB_W-1:0]          in_q1,
    input  logic [ROB_W-1:0]          in_q2,
    input  logic                      in_q1_need,
    input  logic                      in_q2_need,
    input  logic [XLEN-1:0]           in_pc,
    input  logic [XLEN-1:0]           in_imm,
    input  logic [6:0]                in_opcode,
    input  logic [2:0]                in_funct3,
    input  logic                      in_funct7b,
    input  logic [ROB_W-1:0]          in_rob,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0]  cdb_rob,
    input  logic [NUM_CDB*XLEN-1:0]   cdb_val,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_v1,
    output logic [XLEN-1:0]           out_v2,
    output logic [XLEN-1:0]           out_pc,
    output logic [XLEN-1:0]           out_imm,
    output logic [6:0]                out_opcode,
    output logic [2:0]                out_funct3,
    output logic                      out_funct7b,
    output logic [ROB_W-1:0]          out_rob,
    output logic [$clog2(ENTRIES):0]  count
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [ENTRIES-1:0]         used_q, used_n;
    iq_entry_t                  ent_q [ENTRIES];
    iq_entry_t                  ent_n [ENTRIES];
    logic [ENTRIES-1:0]         older_q [ENTRIES];
    logic [ENTRIES-1:0]         older_n [ENTRIES];
    logic [ENTRIES*ENTRIES-1:0] older_flat;
    iq_op_t                     out_q, out_n;
    logic                       out_valid_n;
    logic [CNT_W-1:0]           count_n;
    logic [ENTRIES-1:0]         ready_c, grant_c;
    logic                       grant_valid_c;
    logic [IDX_W-1:0]           grant_idx_c, free_idx_c;
    iq_entry_t                  new_e;
    logic                       do_alloc, issued;

    assign out_v1      = out_q.v1;
    assign out_v2      = out_q.v2;
    assign out_pc      = out_q.pc;
    assign out_imm     = out_q.imm;
    assign out_opcode  = out_q.opcode;
    assign out_funct3  = out_q.funct3;
    assign out_funct7b = out_q.funct7b;
    assign out_rob     = out_q.rob;

    // Readiness comes from registered state only, so a woken entry issues one cycle later
    always_comb begin
        free_idx_c  = '0;
        grant_idx_c = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            ready_c[i] = used_q[i] && !ent_q[i].need1 && !ent_q[i].need2;
            if (!used_q[ENTRIES-1-i]) free_idx_c = IDX_W'(ENTRIES-1-i);
            if (grant_c[i]) grant_idx_c = IDX_W'(i);
            for (int unsigned j = 0; j < ENTRIES; j++) begin
                older_flat[i*ENTRIES+j] = older_q[i][j];
            end
        end
    end

    rs_age_select #(.ENTRIES(ENTRIES)) u_sel (
        .req   (ready_c),
        .older (older_flat),
        .grant (grant_c),
        .valid (grant_valid_c)
    );

    always_comb begin
        int unsigned k;
        used_n      = used_q;
        ent_n       = ent_q;
        older_n     = older_q;
        out_n       = out_q;
        out_valid_n = out_valid;
        do_alloc    = in_valid && in_ready;
        issued      = 1'b0;
        k           = 0;

        new_e.need1      = in_q1_need;
        new_e.need2      = in_q2_need;
        new_e.q1         = in_q1;
        new_e.q2         = in_q2;
        new_e.op.v1      = in_v1;
        new_e.op.v2      = in_v2;
        new_e.op.pc      = in_pc;
        new_e.op.imm     = in_imm;
        new_e.op.opcode  = in_opcode;
        new_e.op.funct3  = in_funct3;
        new_e.op.funct7b = in_funct7b;
        new_e.op.rob     = in_rob;

        // Scan buses high to low so the lowest matching bus index wins
        for (int unsigned kk = 0; kk < NUM_CDB; kk++) begin
            k = NUM_CDB - 1 - kk;
            if (cdb_valid[k]) begin
                for (int unsigned i = 0; i < ENTRIES; i++) begin
                    if (used_q[i] && ent_q[i].need1 && ent_q[i].q1 == cdb_tag(cdb_rob, k)) begin
                        ent_n[i].op.v1 = cdb_value(cdb_val, k);
                        ent_n[i].need1 = 1'b0;
                    end
                    if (used_q[i] && ent_q[i].need2 && ent_q[i].q2 == cdb_tag(cdb_rob, k)) begin
                        ent_n[i].op.v2 = cdb_value(cdb_val, k);
                        ent_n[i].need2 = 1'b0;
                    end
                end
                if (in_q1_need && in_q1 == cdb_tag(cdb_rob, k)) begin
                    new_e.op.v1 = cdb_value(cdb_val, k);
                    new_e.need1 = 1'b0;
                end
                if (in_q2_need && in_q2 == cdb_tag(cdb_rob, k)) begin
                    new_e.op.v2 = cdb_value(cdb_val, k);
                    new_e.need2 = 1'b0;
                end
            end
        end

        if (!out_valid || out_ready) begin
            out_valid_n = grant_valid_c;
            if (grant_valid_c) begin
                out_n                = ent_q[grant_idx_c].op;
                used_n[grant_idx_c]  = 1'b0;
                issued               = 1'b1;
            end
        end

        // New entry is younger than every entry already resident
        if (do_alloc) begin
            ent_n[free_idx_c]   = new_e;
            used_n[free_idx_c]  = 1'b1;
            older_n[free_idx_c] = '0;
            for (int unsigned j = 0; j < ENTRIES; j++) begin
                if (used_q[j]) older_n[j][free_idx_c] = 1'b1;
            end
        end

        count_n = count + CNT_W'(do_alloc) - CNT_W'(issued);

        if (rollback) begin
            used_n      = '0;
            out_valid_n = 1'b0;
            out_n       = '0;
            count_n     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            used_q    <= '0;
            out_valid <= 1'b0;
            out_q     <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ent_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else if (rdy) begin
            used_q    <= used_n;
            out_valid <= out_valid_n;
            out_q     <= out_n;
            count     <= count_n;
            in_ready  <= (count_n < CNT_W'(ENTRIES));
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ent_q[i]   <= ent_n[i];
                older_q[i] <= older_n[i];
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue against an age-ordered list model of the queue.
module tb_issue_queue;
    import issue_pkg::*;

    localparam int E = 16;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic        in_valid, in_ready, in_q1_need, in_q2_need, in_funct7b;
    logic [31:0] in_v1, in_v2, in_pc, in_imm;
    logic [3:0]  in_q1, in_q2, in_rob;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_rob;
    logic [63:0] cdb_val;
    logic        out_valid, out_ready, out_funct7b;
    logic [31:0] out_v1, out_v2, out_pc, out_imm;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [3:0]  out_rob;
    logic [4:0]  count;

    issue_queue dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_v1(in_v1), .in_v2(in_v2), .in_q1(in_q1), .in_q2(in_q2),
        .in_q1_need(in_q1_need), .in_q2_need(in_q2_need),
        .in_pc(in_pc), .in_imm(in_imm), .in_opcode(in_opcode),
        .in_funct3(in_funct3), .in_funct7b(in_funct7b), .in_rob(in_rob),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_val(cdb_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_v1(out_v1), .out_v2(out_v2), .out_pc(out_pc), .out_imm(out_imm),
        .out_opcode(out_opcode), .out_funct3(out_funct3),
        .out_funct7b(out_funct7b), .out_rob(out_rob), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit        n1, n2;
        bit [3:0]  q1, q2;
        bit [31:0] v1, v2, pc, imm;
        bit [6:0]  opc;
        bit [2:0]  f3;
        bit        f7;
        bit [3:0]  rob;
    } op_t;

    op_t mq[$];
    op_t exp_q[$];
    op_t mo;
    bit  mo_valid;
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic op_t capture(input op_t e);
        op_t r = e;
        for (int k = 0; k < 2; k++) begin
            if (cdb_valid[k] && r.n1 && cdb_rob[k*4 +: 4] == e.q1) begin
                r.v1 = cdb_val[k*32 +: 32];
                r.n1 = 1'b0;
            end
            if (cdb_valid[k] && r.n2 && cdb_rob[k*4 +: 4] == e.q2) begin
                r.v2 = cdb_val[k*32 +: 32];
                r.n2 = 1'b0;
            end
        end
        return r;
    endfunction

    // Predicts the effect of the coming clock edge from the inputs now applied
    function automatic void model_step();
        int  pre;
        int  idx;
        op_t e;
        if (rst || (rdy && rollback)) begin
            mq.delete();
            mo       = '0;
            mo_valid = 1'b0;
            return;
        end
        if (!rdy) return;
        pre = mq.size();
        if (mo_valid && out_ready) exp_q.push_back(mo);
        if (!mo_valid || out_ready) begin
            mo_valid = 1'b0;
            idx = -1;
            for (int i = 0; i < mq.size(); i++) begin
                if (idx < 0 && !mq[i].n1 && !mq[i].n2) idx = i;
            end
            if (idx >= 0) begin
                mo       = mq[idx];
                mo_valid = 1'b1;
                mq.delete(idx);
            end
        end
        for (int i = 0; i < mq.size(); i++) mq[i] = capture(mq[i]);
        if (in_valid && pre < E) begin
            e = '{n1: in_q1_need, n2: in_q2_need, q1: in_q1, q2: in_q2,
                  v1: in_v1, v2: in_v2, pc: in_pc, imm: in_imm, opc: in_opcode,
                  f3: in_funct3, f7: in_funct7b, rob: in_rob};
            mq.push_back(capture(e));
        end
    endfunction

    task automatic check_state();
        chk("count", 64'(count), 64'(mq.size()));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < E));
        chk("out_valid", 64'(out_valid), 64'(mo_valid));
        if (mo_valid) begin
            chk("hold_rob", 64'(out_rob), 64'(mo.rob));
            chk("hold_v1", 64'(out_v1), 64'(mo.v1));
            chk("hold_v2", 64'(out_v2), 64'(mo.v2));
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check_state();
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        cdb_valid = 2'b00;
        cdb_rob   = '0;
        cdb_val   = '0;
    endtask

    task automatic disp(input bit n1, input bit [3:0] q1, input bit n2, input bit [3:0] q2,
                        input bit [3:0] rob);
        logic [6:0] opcs [5];
        opcs = '{OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_BRANCH};
        in_valid   = 1'b1;
        in_q1_need = n1;
        in_q1      = q1;
        in_q2_need = n2;
        in_q2      = q2;
        in_rob     = rob;
        in_v1      = $urandom;
        in_v2      = $urandom;
        in_pc      = $urandom;
        in_imm     = $urandom;
        in_opcode  = opcs[$urandom_range(0, 4)];
        in_funct3  = 3'($urandom);
        in_funct7b = 1'($urandom);
    endtask

    // Handshake monitor: every accepted issue must match the next predicted op
    initial begin
        op_t x;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && rdy && !rollback && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got rob %0h expected no issue", out_rob);
                end else begin
                    x = exp_q.pop_front();
                    chk("sb_rob", 64'(out_rob), 64'(x.rob));
                    chk("sb_v1", 64'(out_v1), 64'(x.v1));
                    chk("sb_v2", 64'(out_v2), 64'(x.v2));
                    chk("sb_pc", 64'(out_pc), 64'(x.pc));
                    chk("sb_imm", 64'(out_imm), 64'(x.imm));
                    chk("sb_fields", 64'({out_opcode, out_funct3, out_funct7b}),
                        64'({x.opc, x.f3, x.f7}));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; out_ready = 1'b1;
        idle();
        disp(0, 0, 0, 0, 0);
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'({out_v1, out_rob, out_opcode}), 64'd0);

        // Ready op: one cycle from allocation to issue
        disp(0, 0, 0, 0, 7); tick();
        idle(); tick();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_rob", 64'(out_rob), 64'd7);
        tick();
        chk("t1_count", 64'(count), 64'd0);

        // Younger ready op overtakes older pending one
        disp(1, 3, 0, 0, 1); tick();
        disp(0, 0, 0, 0, 2); tick();
        idle(); cdb_valid = 2'b01; cdb_rob = {4'd0, 4'd3}; cdb_val = {32'd0, 32'h55}; tick();
        chk("t2_first", 64'(out_rob), 64'd2);
        idle(); tick();
        chk("t2_second", 64'(out_rob), 64'd1);
        chk("t2_v1", 64'(out_v1), 64'h55);
        tick();

        // Fill with pending ops, then wake a single tag
        for (int i = 0; i < E; i++) begin
            disp(1, 4'(i), 0, 0, 4'(i)); tick();
        end
        chk("full_count", 64'(count), 64'd16);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        disp(0, 0, 0, 0, 4'hf); tick();
        chk("full_ignored", 64'(count), 64'd16);
        idle(); cdb_valid = 2'b01; cdb_rob = {4'd0, 4'd5}; cdb_val = {32'd0, 32'h1234}; tick();
        idle(); tick();
        chk("full_issue_rob", 64'(out_rob), 64'd5);
        chk("full_reopen", 64'(in_ready), 64'd1);
        tick();
        rollback = 1'b1; tick(); rollback = 1'b0;
        chk("full_flush", 64'(count), 64'd0);

        // Output held under backpressure, then allocation order
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(0, 0, 0, 0, 4'(10 + i)); tick();
        end
        idle();
        repeat (3) tick();
        chk("stall_rob", 64'(out_rob), 64'd10);
        out_ready = 1'b1;
        repeat (4) tick();

        // Dispatch-time bypass from bus 1
        disp(0, 0, 1, 5, 9); cdb_valid = 2'b10; cdb_rob = {4'd5, 4'd0};
        cdb_val = {32'hABCD, 32'd0}; tick();
        idle(); tick();
        chk("bypass_valid", 64'(out_valid), 64'd1);
        chk("bypass_v2", 64'(out_v2), 64'hABCD);
        tick();

        // Rollback with resident entries and a pending output
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            disp(0, 0, 0, 0, 4'(i)); tick();
        end
        idle();
        rollback = 1'b1; tick(); rollback = 1'b0;
        chk("rb_out_valid", 64'(out_valid), 64'd0);
        chk("rb_count", 64'(count), 64'd0);
        out_ready = 1'b1;
        repeat (5) tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            disp(1'($urandom_range(0, 2) == 0), 4'($urandom), 1'($urandom_range(0, 2) == 0),
                 4'($urandom), 4'($urandom));
            in_valid  = ($urandom_range(0, 99) < 60);
            cdb_valid = 2'($urandom);
            cdb_rob   = 8'($urandom);
            cdb_val   = {32'($urandom), 32'($urandom)};
            rdy       = ($urandom_range(0, 99) < 90);
            rollback  = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 99) < 70);
            tick();
        end
        idle(); rdy = 1'b1; rollback = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        rollback = 1'b1; tick(); rollback = 1'b0;
        tick();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
